ml_rowseq_ctrl: RTL and testbench

ML_ROWSEQ_CTRL -- requirements
Module: ml_rowseq_ctrl

---
 rtl/ml_rowseq_pkg.sv | 24 ++
 rtl/ml_pw_timer.sv | 36 +++
 rtl/ml_rowseq_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ml_rowseq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ml_rowseq_pkg.sv
// Shared types for the row-sequencing controller: FSM state encoding and op codes.
package ml_rowseq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_REQ,
        ST_PULSE,
        ST_GAP,
        ST_FIN,
        ST_ABT
    } state_e;

    localparam logic [1:0] OP_WR  = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    function automatic logic op_legal(input logic [1:0] op);
        return op != OP_RSV;
    endfunction

endpackage

// File: rtl/ml_pw_timer.sv
// Word-line pulse timer: load a cycle count, count down while enabled, flag the final cycle.
module ml_pw_timer #(
    parameter int unsigned PW_W = 4
) (
    input  logic            smc_clk,
    input  logic            por_rst,
    input  logic            load,
    input  logic [PW_W-1:0] load_val,
    input  logic            en,
    output logic            expired_c
);

    logic [PW_W-1:0] cnt_q;
    logic [PW_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - PW_W'(1);
        end
    end

    always_ff @(posedge smc_clk or posedge por_rst) begin
        if (por_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of 1 marks the last cycle of the pulse.
    assign expired_c = (cnt_q == PW_W'(1));

endmodule

// File: rtl/ml_rowseq_ctrl.sv
// Row sequencer for the memory cell array: per row, shift the row register, fetch data,
// drive a timed word-line pulse, then a gap cycle; supports write, read and row-clear.
module ml_rowseq_ctrl #(
    parameter int unsigned ROW_W = 9,
    parameter int unsigned PW_W  = 4
) (
    input  logic             smc_clk,
    input  logic             por_rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [ROW_W-1:0] num_rows,
    input  logic [PW_W-1:0]  pw,
    input  logic             data_vld,
    input  logic             abort,
    output logic             data_req,
    output logic [ROW_W-1:0] row_idx,
    output logic             smc_rsr_in,
    output logic             smc_rsr_inc,
    output logic             rsr_rst,
    output logic             cram_wl_en,
    output logic             smc_write,
    output logic             cram_rst,
    output logic             rd_strobe,
    output logic             busy,
    output logic             done,
    output logic             err
);

    import ml_rowseq_pkg::*;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [ROW_W-1:0] num_rows_q, num_rows_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    logic [PW_W-1:0]  pw_q, pw_d;

    logic busy_q, busy_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic data_req_q, data_req_d;
    logic smc_rsr_in_q, smc_rsr_in_d;
    logic smc_rsr_inc_q, smc_rsr_inc_d;
    logic rsr_rst_q, rsr_rst_d;
    logic cram_wl_en_q, cram_wl_en_d;
    logic smc_write_q, smc_write_d;
    logic cram_rst_q, cram_rst_d;
    logic rd_strobe_q, rd_strobe_d;

    logic            start_bad_c;
    logic            pulse_done_c;
    logic            timer_load_c;
    logic [PW_W-1:0] pw_eff_c;

    assign pw_eff_c     = (pw_q == '0) ? PW_W'(1) : pw_q;
    assign timer_load_c = (state_d == ST_PULSE) && (state_q != ST_PULSE);
    assign start_bad_c  = (state_q == ST_IDLE) && start && (!op_legal(op) || (num_rows == '0));

    ml_pw_timer #(
        .PW_W (PW_W)
    ) u_pw_timer (
        .smc_clk   (smc_clk),
        .por_rst   (por_rst),
        .load      (timer_load_c),
        .load_val  (pw_eff_c),
        .en        (state_q == ST_PULSE),
        .expired_c (pulse_done_c)
    );

    // Next state and latched fields.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        num_rows_d = num_rows_q;
        pw_d       = pw_q;
        row_idx_d  = row_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start && op_legal(op) && (num_rows != '0)) begin
                    state_d    = ST_CLR;
                    op_d       = op;
                    num_rows_d = num_rows;
                    pw_d       = pw;
                    row_idx_d  = '0;
                end
            end
            ST_CLR:   state_d = ST_SHIFT;
            ST_SHIFT: state_d = (op_q == OP_CLR) ? ST_PULSE : ST_REQ;
            ST_REQ: begin
                if (data_vld) begin
                    state_d = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (pulse_done_c) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (row_idx_q == (num_rows_q - ROW_W'(1))) begin
                    state_d = ST_FIN;
                end else begin
                    state_d   = ST_SHIFT;
                    row_idx_d = row_idx_q + ROW_W'(1);
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            ST_ABT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // Abort overrides every other transition and freezes the row index.
        if (abort && (state_q != ST_IDLE) && (state_q != ST_ABT)) begin
            state_d   = ST_ABT;
            row_idx_d = row_idx_q;
        end
    end

    // Outputs are decoded from the next state so every strobe comes straight off a flop.
    always_comb begin
        busy_d        = (state_d != ST_IDLE);
        done_d        = (state_d == ST_FIN);
        err_d         = (state_d == ST_ABT) || start_bad_c;
        data_req_d    = (state_d == ST_REQ);
        smc_rsr_inc_d = (state_d == ST_SHIFT);
        smc_rsr_in_d  = (state_d == ST_SHIFT) && (row_idx_d == '0);
        rsr_rst_d     = (state_d == ST_CLR) || (state_d == ST_FIN) || (state_d == ST_ABT);
        cram_wl_en_d  = (state_d == ST_PULSE);
        smc_write_d   = (state_d == ST_PULSE) && (op_d == OP_WR);
        cram_rst_d    = (state_d == ST_PULSE) && (op_d == OP_CLR);
        rd_strobe_d   = (state_d == ST_GAP) && (op_d == OP_RD);
    end

    always_ff @(posedge smc_clk or posedge por_rst) begin
        if (por_rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            num_rows_q    <= '0;
            pw_q          <= '0;
            row_idx_q     <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            data_req_q    <= 1'b0;
            smc_rsr_in_q  <= 1'b0;
            smc_rsr_inc_q <= 1'b0;
            rsr_rst_q     <= 1'b0;
            cram_wl_en_q  <= 1'b0;
            smc_write_q   <= 1'b0;
            cram_rst_q    <= 1'b0;
            rd_strobe_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            num_rows_q    <= num_rows_d;
            pw_q          <= pw_d;
            row_idx_q     <= row_idx_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
            data_req_q    <= data_req_d;
            smc_rsr_in_q  <= smc_rsr_in_d;
            smc_rsr_inc_q <= smc_rsr_inc_d;
            rsr_rst_q     <= rsr_rst_d;
            cram_wl_en_q  <= cram_wl_en_d;
            smc_write_q   <= smc_write_d;
            cram_rst_q    <= cram_rst_d;
            rd_strobe_q   <= rd_strobe_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign data_req    = data_req_q;
    assign row_idx     = row_idx_q;
    assign smc_rsr_in  = smc_rsr_in_q;
    assign smc_rsr_inc = smc_rsr_inc_q;
    assign rsr_rst     = rsr_rst_q;
    assign cram_wl_en  = cram_wl_en_q;
    assign smc_write   = smc_write_q;
    assign cram_rst    = cram_rst_q;
    assign rd_strobe   = rd_strobe_q;

endmodule

// File: tb/tb_ml_rowseq_ctrl.sv
// Bench for ml_rowseq_ctrl: each sequence is expanded into an expected per-cycle output
// trace from its parameters, then compared cycle by cycle against the DUT.
module tb_ml_rowseq_ctrl;

    localparam int unsigned ROW_W = 9;
    localparam int unsigned PW_W  = 4;

    logic             smc_clk;
    logic             por_rst;
    logic             start;
    logic [1:0]       op;
    logic [ROW_W-1:0] num_rows;
    logic [PW_W-1:0]  pw;
    logic             data_vld;
    logic             abort;
    logic             data_req;
    logic [ROW_W-1:0] row_idx;
    logic             smc_rsr_in, smc_rsr_inc, rsr_rst;
    logic             cram_wl_en, smc_write, cram_rst;
    logic             rd_strobe, busy, done, err;

    logic [10:0] outs;
    assign outs = {busy, done, err, data_req, smc_rsr_in, smc_rsr_inc, rsr_rst,
                   cram_wl_en, smc_write, cram_rst, rd_strobe};

    ml_rowseq_ctrl #(
        .ROW_W (ROW_W),
        .PW_W  (PW_W)
    ) dut (
        .smc_clk     (smc_clk),
        .por_rst     (por_rst),
        .start       (start),
        .op          (op),
        .num_rows    (num_rows),
        .pw          (pw),
        .data_vld    (data_vld),
        .abort       (abort),
        .data_req    (data_req),
        .row_idx     (row_idx),
        .smc_rsr_in  (smc_rsr_in),
        .smc_rsr_inc (smc_rsr_inc),
        .rsr_rst     (rsr_rst),
        .cram_wl_en  (cram_wl_en),
        .smc_write   (smc_write),
        .cram_rst    (cram_rst),
        .rd_strobe   (rd_strobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial smc_clk = 1'b0;
    always #5 smc_clk = ~smc_clk;

    int n_vec = 0;
    int n_err = 0;
    int last_row = 0;

    // Expected trace: output vector, row index and data_vld to drive, per busy cycle.
    logic [10:0] eo[$];
    int          er[$];
    bit          ev[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Busy-cycle output vector; busy is always set inside a sequence.
    function automatic logic [10:0] ov(input bit dn, input bit e, input bit rq, input bit rin,
                                       input bit inc, input bit rrs, input bit wl, input bit wr,
                                       input bit crs, input bit rds);
        return {1'b1, dn, e, rq, rin, inc, rrs, wl, wr, crs, rds};
    endfunction

    task automatic push(input logic [10:0] o, input int r, input bit v);
        eo.push_back(o);
        er.push_back(r);
        ev.push_back(v);
    endtask

    task automatic run_txn(input logic [1:0] t_op, input int n, input int t_pw, input int dfix,
                           input int abort_at, input int rst_at);
        int pe;
        int d;
        pe = (t_pw == 0) ? 1 : t_pw;
        eo.delete();
        er.delete();
        ev.delete();
        push(ov(0,0,0,0,0,1,0,0,0,0), 0, rnd_bit());
        for (int r = 0; r < n; r++) begin
            push(ov(0,0,0,(r == 0),1,0,0,0,0,0), r, rnd_bit());
            if (t_op != 2'b10) begin
                d = (dfix > 0) ? dfix : int'($urandom_range(1, 4));
                for (int k = 0; k < d; k++) push(ov(0,0,1,0,0,0,0,0,0,0), r, (k == d - 1));
            end
            for (int k = 0; k < pe; k++)
                push(ov(0,0,0,0,0,0,1,(t_op == 2'b00),(t_op == 2'b10),0), r, rnd_bit());
            push(ov(0,0,0,0,0,0,0,0,0,(t_op == 2'b01)), r, rnd_bit());
        end
        push(ov(1,0,0,0,0,1,0,0,0,0), n - 1, rnd_bit());
        if (abort_at >= 0 && abort_at < eo.size()) begin
            while (eo.size() > abort_at + 1) begin
                void'(eo.pop_back());
                void'(er.pop_back());
                void'(ev.pop_back());
            end
            push(ov(0,1,0,0,0,1,0,0,0,0), er[abort_at], rnd_bit());
        end

        start    = 1'b1;
        op       = t_op;
        num_rows = ROW_W'(n);
        pw       = PW_W'(t_pw);
        abort    = 1'b0;
        data_vld = rnd_bit();
        @(negedge smc_clk);
        for (int i = 0; i < eo.size(); i++) begin
            check("outs", 32'(outs), 32'(eo[i]));
            check("row_idx", 32'(row_idx), 32'(er[i]));
            if (i == rst_at) begin
                start    = 1'b0;
                abort    = 1'b0;
                data_vld = 1'b0;
                #2 por_rst = 1'b1;
                #1;
                check("rst_outs", 32'(outs), 32'h0);
                check("rst_row", 32'(row_idx), 32'h0);
                @(negedge smc_clk);
                por_rst  = 1'b0;
                last_row = 0;
                return;
            end
            data_vld = ev[i];
            abort    = (i == abort_at);
            start    = ($urandom_range(0, 3) == 0);
            op       = 2'($urandom);
            num_rows = ROW_W'($urandom);
            pw       = PW_W'($urandom);
            @(negedge smc_clk);
        end
        start    = 1'b0;
        abort    = 1'b0;
        data_vld = rnd_bit();
        last_row = er[er.size() - 1];
        check("idle_outs", 32'(outs), 32'h0);
        check("idle_row", 32'(row_idx), 32'(last_row));
    endtask

    task automatic bad_start(input logic [1:0] t_op, input int n);
        start    = 1'b1;
        op       = t_op;
        num_rows = ROW_W'(n);
        pw       = PW_W'($urandom);
        data_vld = rnd_bit();
        abort    = rnd_bit();
        @(negedge smc_clk);
        start = 1'b0;
        abort = rnd_bit();
        check("bad_err", 32'(outs), 32'h100);
        check("bad_row", 32'(row_idx), 32'(last_row));
        @(negedge smc_clk);
        abort = 1'b0;
        check("bad_idle", 32'(outs), 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors", n_vec);
        $fatal(1);
    end

    initial begin
        int t_pw;
        por_rst  = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        num_rows = '0;
        pw       = '0;
        data_vld = 1'b0;
        abort    = 1'b0;
        repeat (2) @(negedge smc_clk);
        check("reset_outs", 32'(outs), 32'h0);
        check("reset_row", 32'(row_idx), 32'h0);
        por_rst = 1'b0;
        @(negedge smc_clk);
        check("post_reset_idle", 32'(outs), 32'h0);

        run_txn(2'b00, 3, 2, 2, -1, -1);   // write, 3 rows, 2-cycle pulses
        run_txn(2'b10, 2, 0, 0, -1, -1);   // row-clear, pw 0 -> 1-cycle pulses
        run_txn(2'b01, 1, 3, 5, -1, -1);   // read, data_req held 5 cycles
        bad_start(2'b00, 0);
        bad_start(2'b11, 4);
        run_txn(2'b00, 3, 3, 1, 10, -1);   // abort mid PULSE of row 1
        run_txn(2'b01, 2, 2, 6, -1, 3);    // reset mid REQ
        run_txn(2'b00, 2, 1, 1, -1, -1);   // first sequence after reset

        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 9) == 0) begin
                if (rnd_bit()) bad_start(2'b11, int'($urandom_range(0, 511)));
                else           bad_start(2'($urandom_range(0, 2)), 0);
            end else begin
                t_pw = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 15))
                                                   : int'($urandom_range(0, 3));
                run_txn(2'($urandom_range(0, 2)), int'($urandom_range(1, 6)), t_pw, 0,
                        ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1, -1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
